// File: rtl/ucsbece154_mem_arbiter.sv
// Two-requester arbiter for the instruction-memory burst port: icache refills
// win by default, the prefetcher is forced through after MAX_WAIT lost rounds.
module ucsbece154_mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int MAX_WAIT    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_grant,
  output logic        i_valid,
  output logic        i_done,
  input  logic        p_req,
  input  logic [31:0] p_addr,
  input  logic        p_flush,
  output logic        p_grant,
  output logic        p_valid,
  output logic        p_done,
  output logic [31:0] rd_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_ready,
  output logic        busy
);

  localparam int CNT_W  = $clog2(BLOCK_WORDS);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    BURST_I,
    BURST_P,
    DRAIN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  word_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic p_live;
  logic prefer_p;
  logic last_word;

  // A prefetch request raised together with a flush is already stale.
  assign p_live    = p_req & ~p_flush;
  assign prefer_p  = p_live & (~i_req | (wait_cnt == WAIT_LIMIT));
  assign last_word = mem_ready & (word_cnt == LAST_WORD);

  // Word delivery is a same-cycle pass-through of the imem strobe.
  assign i_valid = (state == BURST_I) & mem_ready;
  assign i_done  = i_valid & (word_cnt == LAST_WORD);
  assign p_valid = (state == BURST_P) & mem_ready & ~p_flush;
  assign p_done  = p_valid & (word_cnt == LAST_WORD);
  assign rd_data = (i_valid | p_valid) ? mem_data : 32'h0;
  assign busy    = (state != IDLE);

  // NOTE: all state below is sequential, so it uses non-blocking assignments
  // only; mixing in blocking writes here would make results order-dependent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      word_cnt <= '0;
      wait_cnt <= '0;
      mem_addr <= 32'h0;
      mem_req  <= 1'b0;
      i_grant  <= 1'b0;
      p_grant  <= 1'b0;
    end else begin
      // NOTE: defaulting mem_req low every cycle makes it a one-cycle pulse
      // without any extra clear logic.
      mem_req <= 1'b0;

      // The imem always delivers a full block, so every non-idle strobe counts.
      if (state != IDLE && mem_ready) begin
        word_cnt <= word_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (!p_req) begin
            wait_cnt <= '0;
          end
          if (prefer_p) begin
            state    <= BURST_P;
            p_grant  <= 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= p_addr;
            wait_cnt <= '0;
          end else if (i_req) begin
            state    <= BURST_I;
            i_grant  <= 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= i_addr;
            if (p_req && wait_cnt != WAIT_LIMIT) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end

        BURST_I: begin
          if (last_word) begin
            state   <= IDLE;
            i_grant <= 1'b0;
          end
        end

        BURST_P: begin
          if (last_word) begin
            state   <= IDLE;
            p_grant <= 1'b0;
          end else if (p_flush) begin
            state   <= DRAIN;
            p_grant <= 1'b0;
          end
        end

        DRAIN: begin
          if (last_word) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// Directed bench for the imem arbiter: a transaction-level model predicts every
// output each cycle, and scenario code pins key events with literal values.
module tb_ucsbece154_mem_arbiter;

  localparam int BW       = 4;
  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, p_req, p_flush, mem_ready;
  logic [31:0] i_addr, p_addr, mem_data;
  logic        i_grant, i_valid, i_done, p_grant, p_valid, p_done, mem_req, busy;
  logic [31:0] rd_data, mem_addr;

  int checks = 0;
  int errors = 0;

  ucsbece154_mem_arbiter #(.BLOCK_WORDS(BW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_valid(i_valid), .i_done(i_done),
    .p_req(p_req), .p_addr(p_addr), .p_flush(p_flush), .p_grant(p_grant),
    .p_valid(p_valid), .p_done(p_done), .rd_data(rd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: who owns the port (0 none, 1 icache, 2 prefetch,
  // 3 discarded prefetch), words seen so far, and icache wins while prefetch waits.
  int          owner = 0;
  int          seen  = 0;
  int          lost  = 0;
  bit          start = 0;
  logic [31:0] burst_addr = 32'h0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner = 0; seen = 0; lost = 0; start = 0; burst_addr = 32'h0;
    end else begin
      start = 0;
      if (owner == 0) begin
        if (!p_req) lost = 0;
        if (p_req && !p_flush && (!i_req || lost >= MAX_WAIT)) begin
          owner = 2; start = 1; burst_addr = p_addr; lost = 0;
        end else if (i_req) begin
          owner = 1; start = 1; burst_addr = i_addr;
          if (p_req && lost < MAX_WAIT) lost = lost + 1;
        end
      end else begin
        if (mem_ready) seen = seen + 1;
        if (seen == BW) begin
          seen = 0; owner = 0;
        end else if (owner == 2 && p_flush) begin
          owner = 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ev_i, ev_p, last;
    last = (seen == BW - 1);
    ev_i = (owner == 1) && mem_ready;
    ev_p = (owner == 2) && mem_ready && !p_flush;
    check("m_i_valid",  i_valid,  ev_i);
    check("m_i_done",   i_done,   ev_i && last);
    check("m_p_valid",  p_valid,  ev_p);
    check("m_p_done",   p_done,   ev_p && last);
    check("m_rd_data",  rd_data,  (ev_i || ev_p) ? mem_data : 32'h0);
    check("m_i_grant",  i_grant,  owner == 1);
    check("m_p_grant",  p_grant,  owner == 2);
    check("m_mem_req",  mem_req,  start);
    check("m_mem_addr", mem_addr, burst_addr);
    check("m_busy",     busy,     owner != 0);
  end

  // One idle arbitration cycle, then the burst-start cycle is inspected.
  task automatic grant_cycle(input string nm, input bit ei, input bit ep, input logic [31:0] ea);
    @(negedge clk);
    check({nm, "_idle_busy"}, busy, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, "_mem_req"},  mem_req,  1'b1);
    check({nm, "_i_grant"},  i_grant,  ei);
    check({nm, "_p_grant"},  p_grant,  ep);
    check({nm, "_mem_addr"}, mem_addr, ea);
    @(posedge clk); #1;
  endtask

  // Supplies one block of back-to-back words base*1 .. base*BW, optionally
  // flushing on word index flush_at, and tallies what the DUT delivered.
  task automatic feed(input logic [31:0] base, input int flush_at,
                      input bit drop_i, input bit drop_p,
                      output int n_iv, output int n_id, output int n_pv, output int n_pd,
                      output logic [31:0] last_rd);
    n_iv = 0; n_id = 0; n_pv = 0; n_pd = 0; last_rd = 32'h0;
    for (int k = 0; k < BW; k++) begin
      mem_ready = 1'b1;
      mem_data  = base * 32'(k + 1);
      p_flush   = (k == flush_at);
      @(negedge clk);
      n_iv += int'(i_valid); n_id += int'(i_done);
      n_pv += int'(p_valid); n_pd += int'(p_done);
      last_rd = rd_data;
      @(posedge clk); #1;
      if (k == flush_at) p_req = 1'b0;
    end
    mem_ready = 1'b0; mem_data = 32'h0; p_flush = 1'b0;
    if (drop_i) i_req = 1'b0;
    if (drop_p) p_req = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, limit 20000 expected earlier");
    $fatal(1);
  end

  initial begin
    int n_iv, n_id, n_pv, n_pd;
    logic [31:0] lr;
    reset = 1'b1;
    i_req = 0; p_req = 0; p_flush = 0; mem_ready = 0;
    i_addr = 0; p_addr = 0; mem_data = 0;
    #1 reset = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_grants", {i_grant, p_grant, mem_req}, 3'b000);
    @(posedge clk); #1 reset = 1'b1;

    // Single icache miss.
    i_req = 1; i_addr = 32'h40;
    grant_cycle("miss", 1, 0, 32'h40);
    feed(32'h11, -1, 1, 0, n_iv, n_id, n_pv, n_pd, lr);
    check("miss_valids", n_iv, 4);
    check("miss_done", n_id, 1);
    check("miss_last_word", lr, 32'h44);
    @(negedge clk);
    check("miss_busy_after", busy, 1'b0);
    @(posedge clk); #1;

    // Simultaneous requests: icache first, then prefetch.
    i_req = 1; i_addr = 32'h100; p_req = 1; p_addr = 32'h80;
    grant_cycle("sim_i", 1, 0, 32'h100);
    feed(32'h1000, -1, 1, 0, n_iv, n_id, n_pv, n_pd, lr);
    grant_cycle("sim_p", 0, 1, 32'h80);
    feed(32'h2000, -1, 0, 1, n_iv, n_id, n_pv, n_pd, lr);
    check("sim_p_valids", n_pv, 4);
    check("sim_p_done", n_pd, 1);

    // Starvation guard: three icache bursts, then the held prefetch wins.
    i_req = 1; i_addr = 32'h200; p_req = 1; p_addr = 32'hC0;
    grant_cycle("stv0", 1, 0, 32'h200);
    feed(32'h3000, -1, 0, 0, n_iv, n_id, n_pv, n_pd, lr);
    i_addr = 32'h210;
    grant_cycle("stv1", 1, 0, 32'h210);
    feed(32'h3100, -1, 0, 0, n_iv, n_id, n_pv, n_pd, lr);
    i_addr = 32'h220;
    grant_cycle("stv2", 1, 0, 32'h220);
    feed(32'h3200, -1, 0, 0, n_iv, n_id, n_pv, n_pd, lr);
    i_addr = 32'h230;
    grant_cycle("stv3", 0, 1, 32'hC0);
    feed(32'h3300, -1, 0, 1, n_iv, n_id, n_pv, n_pd, lr);
    grant_cycle("stv4", 1, 0, 32'h230);
    feed(32'h3400, -1, 1, 0, n_iv, n_id, n_pv, n_pd, lr);

    // Flush mid-prefetch with an icache miss waiting behind it.
    p_req = 1; p_addr = 32'h300;
    grant_cycle("fl_p", 0, 1, 32'h300);
    i_req = 1; i_addr = 32'h400;
    feed(32'h4000, 2, 0, 0, n_iv, n_id, n_pv, n_pd, lr);
    check("fl_p_valids", n_pv, 2);
    check("fl_p_done", n_pd, 0);
    check("fl_no_i_valid", n_iv, 0);
    grant_cycle("fl_i", 1, 0, 32'h400);
    feed(32'h5000, -1, 1, 0, n_iv, n_id, n_pv, n_pd, lr);

    // Flush on the last word goes straight back to idle.
    p_req = 1; p_addr = 32'h500;
    grant_cycle("fl_last", 0, 1, 32'h500);
    feed(32'h6000, 3, 0, 0, n_iv, n_id, n_pv, n_pd, lr);
    check("fl_last_valids", n_pv, 3);
    check("fl_last_done", n_pd, 0);
    @(negedge clk);
    check("fl_last_idle", busy, 1'b0);
    @(posedge clk); #1;

    // Request raised together with a flush is not granted.
    p_req = 1; p_addr = 32'h580; p_flush = 1;
    @(negedge clk); @(posedge clk); #1;
    p_req = 0; p_flush = 0;
    @(negedge clk);
    check("reqfl_grant", p_grant, 1'b0);
    check("reqfl_mem_req", mem_req, 1'b0);
    check("reqfl_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset after the first word of an icache burst.
    i_req = 1; i_addr = 32'h600;
    grant_cycle("rst_burst", 1, 0, 32'h600);
    mem_ready = 1; mem_data = 32'h66;
    @(negedge clk);
    check("rst_word1_valid", i_valid, 1'b1);
    @(posedge clk); #1;
    mem_data = 32'h99;
    #2 reset = 1'b0;
    #1;
    check("arst_grant", i_grant, 1'b0);
    check("arst_valid", i_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_mem_addr", mem_addr, 32'h0);
    check("arst_rd_data", rd_data, 32'h0);
    mem_ready = 0; mem_data = 0; i_req = 0;
    @(posedge clk); #3;
    reset = 1'b1; i_req = 1; i_addr = 32'h700;
    grant_cycle("post_rst", 1, 0, 32'h700);
    feed(32'h7000, -1, 1, 0, n_iv, n_id, n_pv, n_pd, lr);
    check("post_rst_valids", n_iv, 4);
    check("post_rst_done", n_id, 1);
    check("post_rst_last", lr, 32'h1C000);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucsbece154_mem_arbiter.md
Name: ucsbece154_mem_arbiter

Overview:
- Shares the single instruction-memory (SDRAM model) read port between two requesters: the icache refill engine (high priority) and the next-line prefetcher (low priority).
- Serializes whole-block bursts, steers returned words to the owner and guarantees the prefetcher cannot starve.
- Aborts prefetch delivery on a flush without corrupting the memory burst protocol.
- Sits between ucsbece154_icache/prefetcher and ucsbece154_imem in ucsbece154b_top.

Parameters:
- BLOCK_WORDS, 4, words returned per memory burst (power of 2, 2..16).
- MAX_WAIT, 3, consecutive icache grants while prefetch is pending before prefetch is forced to win.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  icache refill request; held until i_done.
- i_addr  in  32  icache block address; stable while i_req is high.
- i_grant  out  1  icache owns memory port.
- i_valid  out  1  rd_data is a word for the icache.
- i_done  out  1  last icache word this cycle.
- p_req  in  1  prefetch request; held until p_done or dropped after p_flush.
- p_addr  in  32  prefetch block address.
- p_flush  in  1  misprediction/redirect; cancels prefetch delivery.
- p_grant  out  1  prefetcher owns memory port.
- p_valid  out  1  rd_data is a word for the prefetcher.
- p_done  out  1  last prefetch word this cycle.
- rd_data  out  32  returned word, shared by both requesters.
- mem_req  out  1  one-cycle burst start pulse to imem.
- mem_addr  out  32  latched burst address.
- mem_data  in  32  imem data word.
- mem_ready  in  1  imem word-valid strobe.
- busy  out  1  arbiter not IDLE.

Behaviour:
- States: IDLE, BURST_I, BURST_P, DRAIN.
- Reset (reset=0, async): state IDLE; word count 0, wait count 0, mem_addr 0. All outputs 0, including mem_req, grants, valids, dones and rd_data. Reset mid-burst abandons the burst; the imem is reset by its own reset.
- IDLE, arbitration evaluated each cycle on registered inputs:
  - i_req only -> BURST_I.
  - p_req only -> BURST_P.
  - Both -> BURST_I, unless wait count == MAX_WAIT, then BURST_P.
  - p_req with p_flush high the same cycle is not granted.
- Entering a BURST state (cycle N+1 after request seen in N):
  - mem_addr latches the winner's address unchanged; requesters supply block-aligned addresses.
  - mem_req = 1 for exactly cycle N+1.
  - Grant rises in N+1 and holds until the cycle after the last word.
- Wait count:
  - Increments (saturating at MAX_WAIT) on each BURST_I grant taken while p_req is high.
  - Clears on a BURST_P grant, or on any cycle with p_req low in IDLE.
- In BURST_x, each cycle with mem_ready = 1:
  - rd_data = mem_data (combinational pass-through).
  - x_valid = 1; the word counter increments modulo BLOCK_WORDS.
  - On the BLOCK_WORDS-th word, x_done = 1 the same cycle, and the state returns to IDLE next cycle.
  - The earliest next grant is the cycle after that, giving a one-idle-cycle turnaround.
- mem_ready in IDLE is ignored: no valid, no count.
- p_flush:
  - In BURST_P, the next state is DRAIN; p_grant drops next cycle.
  - DRAIN keeps counting mem_ready strobes until BLOCK_WORDS total, with p_valid/p_done suppressed, rd_data = 0 and no grant. It then returns to IDLE.
  - A flush on the cycle of the last word: that word is suppressed, p_done = 0, and the state goes to IDLE directly.
  - p_flush in BURST_I, IDLE or DRAIN has no effect.
- An i_req arriving during BURST_P or DRAIN waits; it is not preemptive.
- busy = (state != IDLE).
- Word count is log2(BLOCK_WORDS) bits; wrap to 0 marks block end.

Test Plan:
- Single icache miss: i_req=1, i_addr=0x0000_0040, imem returns 4 words 0x11,0x22,0x33,0x44 -> mem_req pulses 1 cycle with mem_addr=0x40; 4 i_valid strobes with matching rd_data; i_done on 4th; busy low the next cycle.
- Simultaneous request: i_req and p_req (p_addr=0x80) in the same cycle -> icache served first; prefetch granted 1 cycle after i_done with mem_addr=0x80.
- Starvation: p_req held while 4 back-to-back icache misses arrive (MAX_WAIT=3) -> 3 icache bursts, then a prefetch burst even though i_req is high, then icache.
- Flush mid-prefetch: p_flush after the 2nd of 4 prefetch words -> p_valid only for words 1-2, no p_done; DRAIN absorbs words 3-4; a pending i_req is granted after the 4th word plus the idle cycle.
- Flush on last word, and flush with new request: p_flush with 4th word -> no p_done, IDLE next cycle. p_req+p_flush together in IDLE -> no grant.
- Async reset mid-burst: reset low after the 1st of 4 icache words, between clock edges -> all outputs 0 immediately. After release, a fresh i_req starts a new burst with the word count at 0.
